// File: rtl/ula_seq.sv
// ula_seq: registered sequential ALU with Z/N/C/V flags and Busy/Done handshake.
//
// Optional feature macro: ULA_SEQ_MULT_EN
//   defined   -> op 111 is an iterative shift-add multiply taking WIDTH cycles
//   undefined -> op 111 completes in one cycle with Q=0 (Z=1); Busy stays 0
//
// Ports:
//   Clock     in   rising-edge clock
//   Reset     in   asynchronous active-high reset
//   Start     in   operation request, sampled only when idle
//   Operacao  in   [2:0] operation select, latched with Start
//   A         in   [WIDTH-1:0] operand a
//   BusWires  in   [WIDTH-1:0] operand b
//   Q         out  [WIDTH-1:0] registered result
//   Busy      out  high while a multi-cycle operation is in progress
//   Done      out  one-cycle pulse when Q and flags are updated
//   Z,N,C,V   out  zero, negative, carry, signed-overflow flags
module ula_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Operacao,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] BusWires,
  output logic [WIDTH-1:0] Q,
  output logic             Busy,
  output logic             Done,
  output logic             Z,
  output logic             N,
  output logic             C,
  output logic             V
);

  localparam int unsigned W1 = WIDTH + 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
`ifdef ULA_SEQ_MULT_EN
  localparam logic [2:0] OP_MUL = 3'b111;
`endif

  // Result and flag registers (G-register role)
  logic [WIDTH-1:0] q_q, q_d;
  logic             z_q, z_d;
  logic             n_q, n_d;
  logic             c_q, c_d;
  logic             v_q, v_d;
  logic             done_q, done_d;

  // Single-cycle ALU on the live inputs; its result is captured at the Start edge
  logic [WIDTH:0]   sum_c;
  logic [WIDTH-1:0] res_c;
  logic             cy_c;
  logic             ov_c;

  always_comb begin
    sum_c = '0;
    res_c = '0;
    cy_c  = 1'b0;
    ov_c  = 1'b0;
    case (Operacao)
      OP_ADD: begin
        sum_c = {1'b0, A} + {1'b0, BusWires};
        res_c = sum_c[WIDTH-1:0];
        cy_c  = sum_c[WIDTH];
        ov_c  = (A[WIDTH-1] == BusWires[WIDTH-1]) && (res_c[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        // a - b as a + ~b + 1, so carry out means no borrow
        sum_c = {1'b0, A} + {1'b0, ~BusWires} + W1'(1);
        res_c = sum_c[WIDTH-1:0];
        cy_c  = sum_c[WIDTH];
        ov_c  = (A[WIDTH-1] != BusWires[WIDTH-1]) && (res_c[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND: res_c = A & BusWires;
      OP_OR:  res_c = A | BusWires;
      OP_XOR: res_c = A ^ BusWires;
      OP_SHL: res_c = A << BusWires[SHW-1:0];
      OP_SHR: res_c = A >> BusWires[SHW-1:0];
      default: res_c = '0;  // op 111 is handled by the multiplier (or yields 0)
    endcase
  end

`ifdef ULA_SEQ_MULT_EN
  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               busy_q, busy_d;

  // One shift-add step: multiplier sits in the low half and shifts out LSB first
  logic [WIDTH:0]     add_c;
  logic [2*WIDTH-1:0] step_c;

  assign add_c  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : W1'(0));
  assign step_c = {add_c, prod_q[WIDTH-1:1]};
`endif

  // Next-state and result/flag update
  always_comb begin
    q_d    = q_q;
    z_d    = z_q;
    n_d    = n_q;
    c_d    = c_q;
    v_d    = v_q;
    done_d = 1'b0;
`ifdef ULA_SEQ_MULT_EN
    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    busy_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          if (Operacao == OP_MUL) begin
            state_d = S_MUL;
            busy_d  = 1'b1;
            cnt_d   = '0;
            mcand_d = A;
            prod_d  = {{WIDTH{1'b0}}, BusWires};
          end else begin
            q_d    = res_c;
            z_d    = (res_c == '0);
            n_d    = res_c[WIDTH-1];
            c_d    = cy_c;
            v_d    = ov_c;
            done_d = 1'b1;
          end
        end
      end
      S_MUL: begin
        prod_d = step_c;
        cnt_d  = cnt_q + SHW'(1);
        if (cnt_q == SHW'(WIDTH - 1)) begin
          state_d = S_IDLE;
          q_d     = step_c[WIDTH-1:0];
          z_d     = (step_c[WIDTH-1:0] == '0);
          n_d     = step_c[WIDTH-1];
          c_d     = |step_c[2*WIDTH-1:WIDTH];
          v_d     = 1'b0;
          done_d  = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
`else
    if (Start) begin
      q_d    = res_c;
      z_d    = (res_c == '0);
      n_d    = res_c[WIDTH-1];
      c_d    = cy_c;
      v_d    = ov_c;
      done_d = 1'b1;
    end
`endif
  end

  // State and output registers
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      q_q     <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      done_q  <= 1'b0;
`ifdef ULA_SEQ_MULT_EN
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
      busy_q  <= 1'b0;
`endif
    end else begin
      q_q     <= q_d;
      z_q     <= z_d;
      n_q     <= n_d;
      c_q     <= c_d;
      v_q     <= v_d;
      done_q  <= done_d;
`ifdef ULA_SEQ_MULT_EN
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      busy_q  <= busy_d;
`endif
    end
  end

  assign Q    = q_q;
  assign Z    = z_q;
  assign N    = n_q;
  assign C    = c_q;
  assign V    = v_q;
  assign Done = done_q;
`ifdef ULA_SEQ_MULT_EN
  assign Busy = busy_q;
`else
  assign Busy = 1'b0;
`endif

endmodule

// File: tb/tb_ula_seq.sv
// tb_ula_seq: random + directed self-checking bench for ula_seq against a
// behavioural model (plain integer arithmetic, countdown for multiply latency).
module tb_ula_seq;

  localparam int unsigned W = 16;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  logic         Clock;
  logic         Reset;
  logic         Start;
  logic [2:0]   Operacao;
  logic [W-1:0] A;
  logic [W-1:0] BusWires;
  logic [W-1:0] Q;
  logic         Busy, Done, Z, N, C, V;

  int errors = 0;
  int checks = 0;

  // Model state
  logic [W-1:0] m_q;
  bit           m_z, m_n, m_c, m_v, m_done;
  int           m_cnt;
  longint       m_pend;

  ula_seq #(.WIDTH(W)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Operacao(Operacao),
    .A(A), .BusWires(BusWires), .Q(Q), .Busy(Busy), .Done(Done),
    .Z(Z), .N(N), .C(C), .V(V)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q = '0; m_z = 0; m_n = 0; m_c = 0; m_v = 0; m_done = 0;
    m_cnt = 0; m_pend = 0;
  endtask

  task automatic commit(input logic [W-1:0] r, input bit c, input bit v);
    m_q = r; m_z = (r == 0); m_n = r[W-1]; m_c = c; m_v = v; m_done = 1;
  endtask

  // Model update for one rising edge, from the inputs presented at that edge
  task automatic model_step();
    int ua, ub, sa, sb, s;
    logic [W-1:0] r;
    m_done = 0;
    ua = int'(A);
    ub = int'(BusWires);
    sa = int'($signed(A));
    sb = int'($signed(BusWires));
    if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        r = m_pend[W-1:0];
        commit(r, m_pend >= 64'd65536, 0);
      end
    end else if (Start) begin
      case (Operacao)
        OP_ADD: begin
          s = sa + sb;
          commit(W'(ua + ub), (ua + ub) > 65535, (s > 32767) || (s < -32768));
        end
        OP_SUB: begin
          s = sa - sb;
          commit(W'(ua - ub), ua >= ub, (s > 32767) || (s < -32768));
        end
        OP_AND: commit(A & BusWires, 0, 0);
        OP_OR:  commit(A | BusWires, 0, 0);
        OP_XOR: commit(A ^ BusWires, 0, 0);
        OP_SHL: commit(W'(ua << (ub % W)), 0, 0);
        OP_SHR: commit(W'(ua >> (ub % W)), 0, 0);
        default: begin
`ifdef ULA_SEQ_MULT_EN
          m_pend = longint'(ua) * longint'(ub);
          m_cnt  = W;
`else
          commit('0, 0, 0);
`endif
        end
      endcase
    end
  endtask

  // Compare every DUT output against the model
  task automatic compare();
    chk("Q",    32'(Q),    32'(m_q));
    chk("Z",    32'(Z),    32'(m_z));
    chk("N",    32'(N),    32'(m_n));
    chk("C",    32'(C),    32'(m_c));
    chk("V",    32'(V),    32'(m_v));
    chk("Done", 32'(Done), 32'(m_done));
    chk("Busy", 32'(Busy), 32'(m_cnt > 0));
  endtask

  // Drive one cycle from a negedge, step the model at the posedge, compare at the next negedge
  task automatic cycle(input bit s, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    Start = s; Operacao = op; A = a; BusWires = b;
    @(posedge Clock);
    model_step();
    @(negedge Clock);
    compare();
  endtask

  // Mid-cycle asynchronous reset; outputs must clear without a clock edge
  task automatic mid_reset();
    Start = 0;
    @(posedge Clock);
    model_step();
    #2;
    Reset = 1;
    #1;
    model_reset();
    chk("rst_Q",    32'(Q),    32'd0);
    chk("rst_Busy", 32'(Busy), 32'd0);
    chk("rst_Done", 32'(Done), 32'd0);
    chk("rst_Z",    32'(Z),    32'd0);
    chk("rst_NCV",  32'({N, C, V}), 32'd0);
    @(negedge Clock);
    compare();
    Reset = 0;
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    Reset = 1; Start = 0; Operacao = '0; A = '0; BusWires = '0;
    model_reset();
    @(negedge Clock);
    compare();
    @(negedge Clock);
    Reset = 0;

    // ADD overflow into sign bit
    cycle(1, OP_ADD, 16'h7FFF, 16'h0001);
    chk("add_Q", 32'(Q), 32'h8000);
    chk("add_NVCZ", 32'({N, V, C, Z}), 32'b1100);
    chk("add_Done", 32'(Done), 32'd1);
    cycle(0, OP_ADD, 16'h0000, 16'h0000);
    chk("add_Done_pulse", 32'(Done), 32'd0);
    chk("add_Q_hold", 32'(Q), 32'h8000);

    mid_reset();

    // SUB then SHR back-to-back
    cycle(1, OP_SUB, 16'd5, 16'd5);
    chk("sub_Q", 32'(Q), 32'd0);
    chk("sub_ZC", 32'({Z, C}), 32'b11);
    cycle(1, OP_SHR, 16'h8000, 16'h0013);
    chk("shr_Q", 32'(Q), 32'h1000);
    chk("shr_Done", 32'(Done), 32'd1);
    cycle(0, OP_ADD, 16'h0000, 16'h0000);

`ifdef ULA_SEQ_MULT_EN
    // 300*300 = 0x15F90; ADD during Busy must be ignored
    cycle(1, OP_MUL, 16'd300, 16'd300);
    for (int i = 0; i < 15; i++) begin
      if (i == 3) cycle(1, OP_ADD, 16'd1, 16'd1);
      else        cycle(0, OP_ADD, 16'd0, 16'd0);
      chk("mul_busy", 32'(Busy), 32'd1);
      chk("mul_nodone", 32'(Done), 32'd0);
    end
    cycle(0, OP_ADD, 16'd0, 16'd0);
    chk("mul_Done", 32'(Done), 32'd1);
    chk("mul_Busy_low", 32'(Busy), 32'd0);
    chk("mul_Q", 32'(Q), 32'h5F90);
    chk("mul_CZ", 32'({C, Z}), 32'b10);
    cycle(0, OP_ADD, 16'd0, 16'd0);
    chk("mul_Q_hold", 32'(Q), 32'h5F90);
    chk("mul_Done_pulse", 32'(Done), 32'd0);

    // Abort a multiply with reset
    cycle(1, OP_MUL, 16'd3, 16'd4);
    for (int i = 0; i < 5; i++) cycle(0, OP_ADD, 16'd0, 16'd0);
    mid_reset();
    for (int i = 0; i < 20; i++) begin
      cycle(0, OP_ADD, 16'd0, 16'd0);
      chk("abort_nodone", 32'(Done), 32'd0);
    end
    chk("abort_Q", 32'(Q), 32'd0);
    cycle(1, OP_ADD, 16'd2, 16'd2);
    chk("abort_add_Q", 32'(Q), 32'd4);
    chk("abort_add_Done", 32'(Done), 32'd1);
`else
    // Multiply disabled: single-cycle zero result
    cycle(1, OP_ADD, 16'd9, 16'd9);
    cycle(1, OP_MUL, 16'd3, 16'd4);
    chk("mul_off_Done", 32'(Done), 32'd1);
    chk("mul_off_Q", 32'(Q), 32'd0);
    chk("mul_off_Z", 32'(Z), 32'd1);
    chk("mul_off_Busy", 32'(Busy), 32'd0);
`endif
    cycle(0, OP_ADD, 16'd0, 16'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) mid_reset();
      else cycle(bit'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), rnd_val(), rnd_val());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
